// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract with N/Z/C/V flags, CHUNK bits per clock through one ripple slice.
// Latency: Start accepted at edge E0 -> Done pulses in the cycle after edge E0+NCHUNK; no backpressure, Start ignored while Busy.
// Optional CHUNKED_ADD_SUB_ACCUM_EN adds Accum: operand A taken from the current Sum register.
module chunked_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Start,
    input  logic             Sub,
    input  logic             CarryIn,
`ifdef CHUNKED_ADD_SUB_ACCUM_EN
    input  logic             Accum,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              last;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  bx_sh;
    logic [WIDTH-1:0]  res_sh;
    logic [WIDTH-1:0]  res_next;
    logic [WIDTH-1:0]  a_src;
    logic              carry;
    logic [CHUNK:0]    csum;

    assign last = (idx == IDXW'(NCHUNK - 1));

`ifdef CHUNKED_ADD_SUB_ACCUM_EN
    assign a_src = Accum ? Sum : A;
`else
    assign a_src = A;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        Busy       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One CHUNK-bit ripple slice; operands shift down so the active chunk is always at bit 0.
    always_comb begin
        csum     = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, bx_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        res_next = (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK)) | (res_sh >> CHUNK);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sh     <= '0;
            bx_sh    <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            Done     <= 1'b0;
            Sum      <= '0;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                a_sh  <= a_src;
                bx_sh <= Sub ? ~B : B;
                carry <= Sub ? 1'b1 : CarryIn;
                idx   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> CHUNK;
                bx_sh  <= bx_sh >> CHUNK;
                res_sh <= res_next;
                carry  <= csum[CHUNK];
                idx    <= idx + IDXW'(1);
                if (last) begin
                    // On the final chunk the low bits of the shifters hold the operand MSBs.
                    Sum      <= res_next;
                    CarryOut <= csum[CHUNK];
                    Overflow <= (a_sh[CHUNK-1] == bx_sh[CHUNK-1]) && (csum[CHUNK-1] != a_sh[CHUNK-1]);
                    Zero     <= (res_next == '0);
                    Negative <= csum[CHUNK-1];
                    Done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub (WIDTH=32, CHUNK=8) with a cycle-level arithmetic model.
module tb_chunked_add_sub;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             reset_n;
    logic             Start;
    logic             Sub;
    logic             CarryIn;
    logic             Accum;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             CarryOut;
    logic             Overflow;
    logic             Zero;
    logic             Negative;

    int checks   = 0;
    int failures = 0;

    chunked_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Start    (Start),
        .Sub      (Sub),
        .CarryIn  (CarryIn),
`ifdef CHUNKED_ADD_SUB_ACCUM_EN
        .Accum    (Accum),
`endif
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Sum      (Sum),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Zero     (Zero),
        .Negative (Negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: whole-word arithmetic, results appear NCHUNK edges after acceptance.
    logic             m_busy, m_done, m_c, m_v, m_z, m_n;
    logic [WIDTH-1:0] m_sum, m_a, m_bx;
    logic             m_cin;
    int               m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_c = 0; m_v = 0; m_z = 0; m_n = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    logic [WIDTH:0]       uns;
                    logic signed [WIDTH+1:0] sgn;
                    uns   = {1'b0, m_a} + {1'b0, m_bx} + (WIDTH+1)'(m_cin);
                    sgn   = $signed({{2{m_a[WIDTH-1]}}, m_a}) + $signed({{2{m_bx[WIDTH-1]}}, m_bx})
                            + $signed({{(WIDTH+1){1'b0}}, m_cin});
                    m_sum = uns[WIDTH-1:0];
                    m_c   = uns[WIDTH];
                    m_v   = (sgn > $signed({3'b000, {(WIDTH-1){1'b1}}})) ||
                            (sgn < -$signed({3'b001, {(WIDTH-1){1'b0}}}));
                    m_z   = (m_sum == 0);
                    m_n   = m_sum[WIDTH-1];
                    m_done = 1; m_busy = 0;
                end
            end else if (Start) begin
                m_a = A;
`ifdef CHUNKED_ADD_SUB_ACCUM_EN
                if (Accum) m_a = m_sum;
`endif
                m_bx  = Sub ? ~B : B;
                m_cin = Sub ? 1'b1 : CarryIn;
                m_busy = 1; m_cnt = NCHUNK;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if ({Busy, Done, CarryOut, Overflow, Zero, Negative, Sum} !==
                {m_busy, m_done, m_c, m_v, m_z, m_n, m_sum}) begin
                failures++;
                $display("FAIL model_cmp t=%0t got B%b D%b C%b V%b Z%b N%b sum=%h want B%b D%b C%b V%b Z%b N%b sum=%h",
                         $time, Busy, Done, CarryOut, Overflow, Zero, Negative, Sum,
                         m_busy, m_done, m_c, m_v, m_z, m_n, m_sum);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                          input logic cin, input logic acc, output int lat, output int bcyc);
        bit got;
        @(negedge clk);
        A = a; B = b; Sub = sub; CarryIn = cin; Accum = acc; Start = 1'b1;
        lat = 0; bcyc = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            Start = 1'b0;
            lat++;
            if (Busy) bcyc++;
            if (Done) got = 1;
        end
        if (!got) begin
            failures++;
            $display("FAIL done_timeout got=no_done want=done_within_20");
        end
    endtask

    task automatic chk_res(input string name, input logic [WIDTH-1:0] s,
                           input logic c, input logic v, input logic z, input logic n);
        chk({name, "_sum"}, 64'(Sum), 64'(s));
        chk({name, "_cvzn"}, 64'({CarryOut, Overflow, Zero, Negative}), 64'({c, v, z, n}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcyc, dones;
        reset_n = 0; Start = 0; Sub = 0; CarryIn = 0; Accum = 0; A = '0; B = '0;
        #12;
        chk("reset_outputs", 64'({Busy, Done, CarryOut, Overflow, Zero, Negative, Sum}), 64'd0);
        @(negedge clk);
        reset_n = 1;

        // Reset mid-operation aborts with no Done.
        @(negedge clk);
        A = 5; B = 7; Sub = 0; CarryIn = 0; Start = 1;
        @(negedge clk);
        Start = 0;
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("midreset_outputs", 64'({Busy, Done, CarryOut, Overflow, Zero, Negative, Sum}), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midreset_no_done", 64'({Busy, Done}), 64'd0);
        end
        reset_n = 1;
        run_op(5, 7, 0, 0, 0, lat, bcyc);
        chk_res("after_reset", 32'd12, 0, 0, 0, 0);

        run_op(32'h0000_00FF, 32'h0000_0001, 0, 0, 0, lat, bcyc);
        chk("carry_chain_latency", 64'(lat), 64'd5);
        chk("carry_chain_busy", 64'(bcyc), 64'd4);
        chk_res("carry_chain", 32'h0000_0100, 0, 0, 0, 0);

        run_op(32'h7FFF_FFFF, 32'h1, 0, 0, 0, lat, bcyc);
        chk_res("signed_ovf", 32'h8000_0000, 0, 1, 0, 1);
        run_op(32'hFFFF_FFFF, 32'h1, 0, 0, 0, lat, bcyc);
        chk_res("wrap", 32'h0, 1, 0, 1, 0);
        run_op(32'h0000_0010, 32'h0000_0020, 0, 1, 0, lat, bcyc);
        chk_res("carry_in", 32'h31, 0, 0, 0, 0);

        run_op(32'd3, 32'd5, 1, 1, 0, lat, bcyc);
        chk_res("sub_borrow", 32'hFFFF_FFFE, 0, 0, 0, 1);
        run_op(32'h8000_0000, 32'h1, 1, 0, 0, lat, bcyc);
        chk_res("sub_ovf", 32'h7FFF_FFFF, 1, 1, 0, 0);

        // Start held high: one accept per NCHUNK+1 cycles.
        @(negedge clk);
        A = 10; B = 20; Sub = 0; CarryIn = 0; Start = 1;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (Done) dones++;
        end
        Start = 0;
        chk("held_start_dones", 64'(dones), 64'd3);
        chk_res("held_start", 32'd30, 0, 0, 0, 0);

        // Start during Busy must be ignored.
        @(negedge clk);
        A = 10; B = 20; Start = 1;
        @(negedge clk);
        Start = 0;
        @(negedge clk);
        A = 1; B = 1; Start = 1;
        @(negedge clk);
        Start = 0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Done) dones++;
        end
        chk("busy_start_dones", 64'(dones), 64'd1);
        chk("busy_start_sum", 64'(Sum), 64'd30);

        run_op(32'd0, 32'd0, 0, 0, 0, lat, bcyc);
        chk_res("accum_clear", 32'd0, 0, 0, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            run_op(32'd0, 32'd100, 0, 0, 1, lat, bcyc);
`ifdef CHUNKED_ADD_SUB_ACCUM_EN
            chk("accum_sum", 64'(Sum), 64'(100 * k));
`else
            chk("accum_sum", 64'(Sum), 64'd100);
`endif
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
